// File: rtl/qubit_demod_pkg.sv
// Shared constants, FSM state type and the 50-step cos/sin coefficient tables
// used by the demodulation integrator.
package qubit_demod_pkg;

   localparam int LANES       = 5;
   localparam int DATA_W      = 16;
   localparam int PHASE_W     = 8;
   localparam int PHASE_STEPS = 50;
   localparam int COEF_W      = 12;
   localparam int ACC_W       = 48;
   localparam int CNT_W       = 16;

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int SUM_W  = PROD_W + 1;
   localparam int IDX_W  = $clog2(PHASE_STEPS);
   localparam int HALF   = PHASE_STEPS / 2;
   localparam int QUART  = PHASE_STEPS / 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   // round(2047*cos/sin(2*pi*m/50)) for the first quarter turn, m = 0..12
   function automatic int base_cos(input int m);
      case (m)
         0: return 2047;  1: return 2031;  2: return 1983;  3: return 1903;
         4: return 1794;  5: return 1656;  6: return 1492;  7: return 1305;
         8: return 1097;  9: return 872;   10: return 633;  11: return 384;
         12: return 129;
         default: return 0;
      endcase
   endfunction

   function automatic int base_sin(input int m);
      case (m)
         0: return 0;     1: return 257;   2: return 509;   3: return 754;
         4: return 986;   5: return 1203;  6: return 1401;  7: return 1577;
         8: return 1728;  9: return 1852;  10: return 1947; 11: return 2011;
         12: return 2043;
         default: return 0;
      endcase
   endfunction

   // Builds the full table by quarter/half-turn symmetry; entry k at [k*COEF_W +: COEF_W].
   function automatic logic [PHASE_STEPS*COEF_W-1:0] gen_lut(input bit want_sin);
      logic [PHASE_STEPS*COEF_W-1:0] t;
      int m;
      int v;
      t = '0;
      for (int k = 0; k < PHASE_STEPS; k++) begin
         m = (k >= HALF) ? k - HALF : k;
         if (want_sin) v = (m <= QUART) ? base_sin(m) : base_sin(HALF - m);
         else          v = (m <= QUART) ? base_cos(m) : -base_cos(HALF - m);
         if (k >= HALF) v = -v;
         t[k*COEF_W +: COEF_W] = v[COEF_W-1:0];
      end
      return t;
   endfunction

   localparam logic [PHASE_STEPS*COEF_W-1:0] COS_LUT = gen_lut(1'b0);
   localparam logic [PHASE_STEPS*COEF_W-1:0] SIN_LUT = gen_lut(1'b1);

endpackage

// File: rtl/demod_integrator_if.sv
// Beat stream into the integrator and the integrated result/flag bundle out of it.
interface demod_integrator_if;
   import qubit_demod_pkg::*;

   // Valid-only stream: a beat is taken on every clock where in_valid is high;
   // there is no backpressure, and in_first/in_last mean nothing without in_valid.
   logic                       in_valid;
   logic                       in_first;
   logic                       in_last;
   logic [LANES*DATA_W-1:0]    data_i_shift;
   logic [LANES*DATA_W-1:0]    data_q_shift;
   logic [LANES*PHASE_W-1:0]   phase_vals;
   logic                       result_valid;
   logic [ACC_W-1:0]           result_i;
   logic [ACC_W-1:0]           result_q;
   logic [CNT_W-1:0]           result_count;
   logic                       stray_err;
   logic                       abort_err;
   logic                       phase_err;

   modport master (
      output in_valid, in_first, in_last, data_i_shift, data_q_shift, phase_vals,
      input  result_valid, result_i, result_q, result_count,
      input  stray_err, abort_err, phase_err
   );

   modport slave (
      input  in_valid, in_first, in_last, data_i_shift, data_q_shift, phase_vals,
      output result_valid, result_i, result_q, result_count,
      output stray_err, abort_err, phase_err
   );

endinterface

// File: rtl/demod_lane.sv
// One lane: coefficient lookup, full-precision complex rotation, three register stages.
module demod_lane
   import qubit_demod_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] data_i,
   input  logic signed [DATA_W-1:0] data_q,
   input  logic [PHASE_W-1:0]       phase,
   output logic                     phase_bad,
   output logic signed [SUM_W-1:0]  i_rot,
   output logic signed [SUM_W-1:0]  q_rot
);

   logic                     bad_c;
   logic [IDX_W-1:0]         idx;
   logic signed [COEF_W-1:0] cos_c, sin_c;
   logic signed [DATA_W-1:0] d_i, d_q;
   logic signed [COEF_W-1:0] c_cos, c_sin;
   logic signed [PROD_W-1:0] p_ic, p_qs, p_qc, p_is;

   // Out-of-range phase forces zero coefficients so the lane contributes nothing.
   always_comb begin
      bad_c = (phase >= PHASE_W'(PHASE_STEPS));
      idx   = phase[IDX_W-1:0];
      cos_c = '0;
      sin_c = '0;
      if (!bad_c) begin
         cos_c = COS_LUT[idx*COEF_W +: COEF_W];
         sin_c = SIN_LUT[idx*COEF_W +: COEF_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_i       <= '0;
         d_q       <= '0;
         c_cos     <= '0;
         c_sin     <= '0;
         phase_bad <= 1'b0;
         p_ic      <= '0;
         p_qs      <= '0;
         p_qc      <= '0;
         p_is      <= '0;
         i_rot     <= '0;
         q_rot     <= '0;
      end else begin
         d_i       <= data_i;
         d_q       <= data_q;
         c_cos     <= cos_c;
         c_sin     <= sin_c;
         phase_bad <= bad_c;
         p_ic      <= PROD_W'(d_i) * PROD_W'(c_cos);
         p_qs      <= PROD_W'(d_q) * PROD_W'(c_sin);
         p_qc      <= PROD_W'(d_q) * PROD_W'(c_cos);
         p_is      <= PROD_W'(d_i) * PROD_W'(c_sin);
         i_rot     <= SUM_W'(p_ic) + SUM_W'(p_qs);
         q_rot     <= SUM_W'(p_qc) - SUM_W'(p_is);
      end
   end

endmodule

// File: rtl/demod_integrator.sv
// Sums the rotated lanes and integrates them over framed windows, one result per window.
module demod_integrator
   import qubit_demod_pkg::*;
(
   input  logic   clk100,
   input  logic   reset_n,
   demod_integrator_if.slave bus,
   output state_t fsm_state
);

   logic [LANES-1:0]        bad_vec;
   logic signed [SUM_W-1:0] lane_i [LANES];
   logic signed [SUM_W-1:0] lane_q [LANES];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      demod_lane u_lane (
         .clk       (clk100),
         .rst_n     (reset_n),
         .data_i    (bus.data_i_shift[k*DATA_W +: DATA_W]),
         .data_q    (bus.data_q_shift[k*DATA_W +: DATA_W]),
         .phase     (bus.phase_vals[k*PHASE_W +: PHASE_W]),
         .phase_bad (bad_vec[k]),
         .i_rot     (lane_i[k]),
         .q_rot     (lane_q[k])
      );
   end

   // Sideband shift registers; bit 3 lines up with the registered tree sum.
   logic [3:0] v_sr, f_sr, l_sr;
   logic signed [ACC_W-1:0] sum_i_c, sum_q_c, tree_i, tree_q;
   logic signed [ACC_W-1:0] acc_i, acc_q, acc_i_n, acc_q_n;
   logic [CNT_W-1:0]        cnt, cnt_n, cnt_inc;
   state_t                  state, state_n;
   logic                    emit, stray_set, abort_set;
   logic                    res_valid, stray_r, abort_r, phase_r;
   logic [ACC_W-1:0]        res_i, res_q;
   logic [CNT_W-1:0]        res_cnt;

   always_comb begin
      sum_i_c = '0;
      sum_q_c = '0;
      for (int k = 0; k < LANES; k++) begin
         sum_i_c = sum_i_c + ACC_W'(lane_i[k]);
         sum_q_c = sum_q_c + ACC_W'(lane_q[k]);
      end
   end

   always_comb begin
      state_n   = state;
      acc_i_n   = acc_i;
      acc_q_n   = acc_q;
      cnt_n     = cnt;
      emit      = 1'b0;
      stray_set = 1'b0;
      abort_set = 1'b0;
      cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
      if (v_sr[3]) begin
         if (f_sr[3]) begin
            // A first beat always opens a fresh window, dropping any partial one.
            acc_i_n   = tree_i;
            acc_q_n   = tree_q;
            cnt_n     = CNT_W'(1);
            abort_set = (state == ST_ACCUM);
            emit      = l_sr[3];
            state_n   = l_sr[3] ? ST_IDLE : ST_ACCUM;
         end else if (state == ST_ACCUM) begin
            acc_i_n = acc_i + tree_i;
            acc_q_n = acc_q + tree_q;
            cnt_n   = cnt_inc;
            emit    = l_sr[3];
            state_n = l_sr[3] ? ST_IDLE : ST_ACCUM;
         end else begin
            stray_set = 1'b1;
         end
      end
   end

   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         v_sr      <= '0;
         f_sr      <= '0;
         l_sr      <= '0;
         tree_i    <= '0;
         tree_q    <= '0;
         state     <= ST_IDLE;
         acc_i     <= '0;
         acc_q     <= '0;
         cnt       <= '0;
         res_valid <= 1'b0;
         res_i     <= '0;
         res_q     <= '0;
         res_cnt   <= '0;
         stray_r   <= 1'b0;
         abort_r   <= 1'b0;
         phase_r   <= 1'b0;
      end else begin
         v_sr      <= {v_sr[2:0], bus.in_valid};
         f_sr      <= {f_sr[2:0], bus.in_valid & bus.in_first};
         l_sr      <= {l_sr[2:0], bus.in_valid & bus.in_last};
         tree_i    <= sum_i_c;
         tree_q    <= sum_q_c;
         state     <= state_n;
         acc_i     <= acc_i_n;
         acc_q     <= acc_q_n;
         cnt       <= cnt_n;
         res_valid <= emit;
         if (emit) begin
            res_i   <= acc_i_n;
            res_q   <= acc_q_n;
            res_cnt <= cnt_n;
         end
         stray_r   <= stray_r | stray_set;
         abort_r   <= abort_r | abort_set;
         phase_r   <= phase_r | (v_sr[0] & (|bad_vec));
      end
   end

   assign bus.result_valid = res_valid;
   assign bus.result_i     = res_i;
   assign bus.result_q     = res_q;
   assign bus.result_count = res_cnt;
   assign bus.stray_err    = stray_r;
   assign bus.abort_err    = abort_r;
   assign bus.phase_err    = phase_r;
   assign fsm_state        = state;

endmodule

// File: tb/tb_demod_integrator.sv
// Directed-vector bench for demod_integrator: expected results are queued at the
// last beat of each window and matched by a monitor when result_valid pulses.
module tb_demod_integrator;
   import qubit_demod_pkg::*;

   localparam int EXP_W = 2*ACC_W + CNT_W + 32;

   logic        clk100 = 1'b0;
   logic        reset_n = 1'b0;
   state_t      fsm_state;
   int unsigned cyc = 0;

   demod_integrator_if bus();

   demod_integrator dut (
      .clk100    (clk100),
      .reset_n   (reset_n),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   // clock/reset block
   always #5 clk100 = ~clk100;
   always @(posedge clk100) cyc <= cyc + 1;

   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // driver tasks
   task automatic beat(input logic first, input logic last, input int iv, input int qv,
                       input int ph, input int ph0);
      int p;
      @(negedge clk100);
      bus.in_valid = 1'b1;
      bus.in_first = first;
      bus.in_last  = last;
      for (int k = 0; k < LANES; k++) begin
         p = (k == 0) ? ph0 : ph;
         bus.data_i_shift[k*DATA_W +: DATA_W]  = iv[DATA_W-1:0];
         bus.data_q_shift[k*DATA_W +: DATA_W]  = qv[DATA_W-1:0];
         bus.phase_vals[k*PHASE_W +: PHASE_W] = p[PHASE_W-1:0];
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk100);
         bus.in_valid = 1'b0;
         bus.in_first = 1'b0;
         bus.in_last  = 1'b0;
      end
   endtask

   // Called in the same time step as the last beat: result due 5 counter ticks later.
   task automatic expect_result(input longint ri, input longint rq, input int cnt);
      exp_q.push_back({ACC_W'(ri), ACC_W'(rq), CNT_W'(cnt), cyc + 32'd5});
   endtask

   task automatic window(input int n, input int iv, input int qv, input int ph, input int ph0,
                         input longint ri, input longint rq);
      for (int b = 0; b < n; b++) beat(b == 0, b == n - 1, iv, qv, ph, ph0);
      expect_result(ri, rq, n);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, bus.result_valid, 0);
      check({tag, "_result_i"}, longint'($signed(bus.result_i)), 0);
      check({tag, "_result_q"}, longint'($signed(bus.result_q)), 0);
      check({tag, "_count"}, bus.result_count, 0);
      check({tag, "_stray"}, bus.stray_err, 0);
      check({tag, "_abort"}, bus.abort_err, 0);
      check({tag, "_phase"}, bus.phase_err, 0);
      check({tag, "_state"}, fsm_state, ST_IDLE);
   endtask

   // scoreboard monitor
   always @(negedge clk100) begin
      logic [EXP_W-1:0]        e;
      logic signed [ACC_W-1:0] ei, eq;
      logic [CNT_W-1:0]        ec;
      logic [31:0]             et;
      if (bus.result_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: actual i=%0d count=%0d required none (cycle %0d)",
                     $signed(bus.result_i), bus.result_count, cyc);
         end else begin
            e  = exp_q.pop_front();
            ei = e[EXP_W-1 -: ACC_W];
            eq = e[EXP_W-1-ACC_W -: ACC_W];
            ec = e[32 +: CNT_W];
            et = e[31:0];
            check("result_i", longint'($signed(bus.result_i)), longint'(ei));
            check("result_q", longint'($signed(bus.result_q)), longint'(eq));
            check("result_count", bus.result_count, ec);
            check("result_latency_cycle", longint'(cyc), longint'(et));
         end
      end
   end

   initial begin
      bus.in_valid     = 1'b0;
      bus.in_first     = 1'b0;
      bus.in_last      = 1'b0;
      bus.data_i_shift = '0;
      bus.data_q_shift = '0;
      bus.phase_vals   = '0;
      reset_n          = 1'b0;
      repeat (3) @(negedge clk100);
      check_all_zero("reset");
      reset_n = 1'b1;
      idle(2);

      window(10, 1000, 0, 0, 0, 102350000, 0);
      idle(3);
      window(10, 1000, 0, 25, 25, -102350000, 0);
      idle(3);
      window(10, 0, 1000, 0, 0, 0, 102350000);
      idle(3);
      window(1, 1000, 0, 0, 0, 10235000, 0);
      idle(3);
      // back-to-back windows with no bubble
      window(3, 1000, 0, 0, 0, 30705000, 0);
      window(2, -500, 0, 0, 0, -10235000, 0);
      idle(3);
      // phase 5 with a gap mid-window: per beat i=5*(1000*1656+500*1203), q=5*(500*1656-1000*1203)
      beat(1'b1, 1'b0, 1000, 500, 5, 5);
      idle(2);
      beat(1'b0, 1'b1, 1000, 500, 5, 5);
      expect_result(22575000, -3750000, 2);
      idle(3);
      window(1, 1000, 0, 12, 12, 645000, -10215000);
      idle(8);
      check("hold_result_i", longint'($signed(bus.result_i)), 645000);
      check("clean_stray", bus.stray_err, 0);
      check("clean_abort", bus.abort_err, 0);
      check("clean_phase", bus.phase_err, 0);

      // stray beat in IDLE
      beat(1'b0, 1'b0, 1000, 0, 0, 0);
      idle(8);
      check("stray_err_set", bus.stray_err, 1);
      check("stray_state_idle", fsm_state, ST_IDLE);
      check("stray_abort_clear", bus.abort_err, 0);

      // in_first mid-window restarts
      beat(1'b1, 1'b0, 1000, 0, 0, 0);
      beat(1'b0, 1'b0, 1000, 0, 0, 0);
      beat(1'b1, 1'b0, 200, 0, 0, 0);
      beat(1'b0, 1'b0, 200, 0, 0, 0);
      beat(1'b0, 1'b1, 200, 0, 0, 0);
      expect_result(6141000, 0, 3);
      idle(8);
      check("abort_err_set", bus.abort_err, 1);

      // illegal phase on lane 0
      window(1, 1000, 0, 0, 50, 8188000, 0);
      idle(8);
      check("phase_err_set", bus.phase_err, 1);
      check("pending_before_reset", exp_q.size(), 0);

      // reset mid-window
      beat(1'b1, 1'b0, 1000, 0, 0, 0);
      beat(1'b0, 1'b0, 1000, 0, 0, 0);
      @(negedge clk100);
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      reset_n      = 1'b0;
      @(negedge clk100);
      check_all_zero("midreset");
      reset_n = 1'b1;
      idle(12);

      check("all_results_seen", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
